// File: rtl/apb_multi_bridge.sv
// Host memory-interface to APB4 bridge with NUM_SLAVES decoded slave windows.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module apb_multi_bridge #(
    parameter int          NUM_SLAVES  = 4,
    parameter int          PADDR_W     = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic                       sys_clk,
    input  logic                       rst_n,
    input  logic                       host_valid,
    output logic                       host_ready,
    input  logic [31:0]                host_addr,
    input  logic [31:0]                host_wdata,
    input  logic [3:0]                 host_wstrb,
    output logic [31:0]                host_rdata,
    output logic                       host_err,
    output logic [PADDR_W-1:0]         apb_paddr,
    output logic                       apb_pwrite,
    output logic                       apb_penable,
    output logic [3:0]                 apb_pstrb,
    output logic [31:0]                apb_pwdata,
    output logic [NUM_SLAVES-1:0]      apb_psel,
    input  logic [32*NUM_SLAVES-1:0]   apb_prdata,
    input  logic [NUM_SLAVES-1:0]      apb_pready,
    input  logic [NUM_SLAVES-1:0]      apb_pslverr
);

    localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TOP_LO = PADDR_W + SEL_W;

    generate
        if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || PADDR_W < 1 || TOP_LO > 31 ||
            TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
            $error("apb_multi_bridge: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                  r_state;
    logic [SEL_W-1:0]        r_idx;
    logic                    r_host_ready;
    logic [31:0]             r_host_rdata;
    logic                    r_host_err;
    logic [PADDR_W-1:0]      r_paddr;
    logic                    r_pwrite;
    logic                    r_penable;
    logic [3:0]              r_pstrb;
    logic [31:0]             r_pwdata;
    logic [NUM_SLAVES-1:0]   r_psel;

    logic [SEL_W-1:0]        w_idx;
    logic                    w_hit;
    logic [NUM_SLAVES-1:0]   w_onehot;
    logic [31:0]             w_prdata [NUM_SLAVES];
    logic [31:0]             w_sel_rdata;
    logic                    w_sel_ready;
    logic                    w_sel_err;
    logic                    w_is_write;

`ifdef APB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0]             r_tcnt;
`endif

    // Window decode: upper bits must match the region base, index must name a real port.
    assign w_idx      = host_addr[PADDR_W +: SEL_W];
    assign w_hit      = (host_addr[31:TOP_LO] == BASE_ADDR[31:TOP_LO]) &&
                        (32'(w_idx) < NUM_SLAVES);
    assign w_onehot   = NUM_SLAVES'(1) << w_idx;
    assign w_is_write = |host_wstrb;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_prdata
            assign w_prdata[gi] = apb_prdata[32*gi +: 32];
        end
    endgenerate

    // Only the latched slave's response lines are ever looked at.
    assign w_sel_rdata = w_prdata[r_idx];
    assign w_sel_ready = apb_pready[r_idx];
    assign w_sel_err   = apb_pslverr[r_idx];

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_host_ready <= 1'b0;
            r_host_rdata <= '0;
            r_host_err   <= 1'b0;
            r_paddr      <= '0;
            r_pwrite     <= 1'b0;
            r_penable    <= 1'b0;
            r_pstrb      <= '0;
            r_pwdata     <= '0;
            r_psel       <= '0;
`ifdef APB_TIMEOUT_EN
            r_tcnt       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (host_valid) begin
                        if (w_hit) begin
                            r_idx     <= w_idx;
                            r_paddr   <= host_addr[PADDR_W-1:0];
                            r_pwrite  <= w_is_write;
                            r_pstrb   <= host_wstrb;
                            r_pwdata  <= w_is_write ? host_wdata : 32'h0;
                            r_psel    <= w_onehot;
                            r_penable <= 1'b0;
                            r_state   <= S_SETUP;
                        end else begin
                            r_host_rdata <= ERR_RDATA;
                            r_host_err   <= 1'b1;
                            r_host_ready <= 1'b1;
                            r_state      <= S_RESP;
                        end
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    r_tcnt    <= '0;
`endif
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    // pready is checked first so a response on the limit cycle still completes normally.
                    if (w_sel_ready) begin
                        r_host_rdata <= r_pwrite ? 32'h0 : w_sel_rdata;
                        r_host_err   <= w_sel_err;
                        r_host_ready <= 1'b1;
                        r_psel       <= '0;
                        r_penable    <= 1'b0;
                        r_state      <= S_RESP;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (r_tcnt == TO_LAST) begin
                        r_host_rdata <= ERR_RDATA;
                        r_host_err   <= 1'b1;
                        r_host_ready <= 1'b1;
                        r_psel       <= '0;
                        r_penable    <= 1'b0;
                        r_state      <= S_RESP;
                    end else begin
                        r_tcnt <= r_tcnt + 16'd1;
                    end
`endif
                end
                S_RESP: begin
                    r_host_ready <= 1'b0;
                    r_host_rdata <= '0;
                    r_host_err   <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign host_ready  = r_host_ready;
    assign host_rdata  = r_host_rdata;
    assign host_err    = r_host_err;
    assign apb_paddr   = r_paddr;
    assign apb_pwrite  = r_pwrite;
    assign apb_penable = r_penable;
    assign apb_pstrb   = r_pstrb;
    assign apb_pwdata  = r_pwdata;
    assign apb_psel    = r_psel;

endmodule
